// File: rtl/tea_engine.sv
// tea_engine: TEA block-cipher engine with valid/ready handshakes on both sides.
// Each block is encrypted or decrypted according to the mode sampled at accept.
// UNROLL cipher cycles are chained combinationally per clock, so a block takes
// ROUNDS/UNROLL clocks from the accept edge to out_valid.
// Optional feature macro: TEA_XTEA_EN adds port in_xtea, which selects XTEA per block.
module tea_engine #(
    parameter int unsigned ROUNDS = 32,
    parameter int unsigned UNROLL = 1,
    parameter logic [31:0] DELTA  = 32'h9E3779B9
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_decrypt,
    input  logic [63:0]  in_data,
    input  logic [127:0] in_key,
`ifdef TEA_XTEA_EN
    input  logic         in_xtea,
`endif
    output logic         out_valid,
    input  logic         out_ready,
    output logic [63:0]  out_data,
    output logic         busy
);

    // Illegal configurations stop elaboration.
    if (ROUNDS < 1 || ROUNDS > 64) begin : g_bad_rounds
        $fatal(1, "tea_engine: ROUNDS must be in 1..64");
    end
    if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 4)) begin : g_bad_unroll
        $fatal(1, "tea_engine: UNROLL must be 1, 2 or 4");
    end
    if (UNROLL != 0 && (ROUNDS % UNROLL) != 0) begin : g_bad_divide
        $fatal(1, "tea_engine: UNROLL must divide ROUNDS");
    end

    localparam int unsigned STEPS    = ROUNDS / UNROLL;
    localparam logic [6:0]  CNT_LOAD = 7'(STEPS);
    // Decrypt starts from the sum the encrypt schedule ends on.
    localparam logic [31:0] SUM_DEC  = DELTA * 32'(ROUNDS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t         state;
    logic [6:0]     cnt;
    logic [31:0]    v0_r;
    logic [31:0]    v1_r;
    logic [31:0]    sum_r;
    logic [127:0]   key_r;
    logic           dec_r;
`ifdef TEA_XTEA_EN
    logic           xt_r;
`endif
    logic [95:0]    next_st;
    logic           accept;

    // TEA round function: ((x<<4)+a) ^ (x+s) ^ ((x>>5)+b).
    function automatic logic [31:0] tea_f(input logic [31:0] x, input logic [31:0] s,
                                          input logic [31:0] a, input logic [31:0] b);
        return ((x << 4) + a) ^ (x + s) ^ ((x >> 5) + b);
    endfunction

    // One TEA cycle on {sum, v0, v1}; decrypt undoes encrypt step by step in reverse order.
    function automatic logic [95:0] tea_step(input logic [95:0] st, input logic [127:0] k,
                                             input logic de);
        logic [31:0] s;
        logic [31:0] v0;
        logic [31:0] v1;
        {s, v0, v1} = st;
        if (!de) begin
            s  = s + DELTA;
            v0 = v0 + tea_f(v1, s, k[127:96], k[95:64]);
            v1 = v1 + tea_f(v0, s, k[63:32], k[31:0]);
        end else begin
            v1 = v1 - tea_f(v0, s, k[63:32], k[31:0]);
            v0 = v0 - tea_f(v1, s, k[127:96], k[95:64]);
            s  = s - DELTA;
        end
        return {s, v0, v1};
    endfunction

`ifdef TEA_XTEA_EN
    // Key word K[i], with K[0] taken from the top of the key bus.
    function automatic logic [31:0] key_word(input logic [127:0] k, input logic [1:0] i);
        logic [31:0] w;
        case (i)
            2'd0:    w = k[127:96];
            2'd1:    w = k[95:64];
            2'd2:    w = k[63:32];
            default: w = k[31:0];
        endcase
        return w;
    endfunction

    function automatic logic [31:0] xtea_mix(input logic [31:0] x);
        return ((x << 4) ^ (x >> 5)) + x;
    endfunction

    // One XTEA cycle on {sum, v0, v1}; the sum update sits between the two half-updates.
    function automatic logic [95:0] xtea_step(input logic [95:0] st, input logic [127:0] k,
                                              input logic de);
        logic [31:0] s;
        logic [31:0] v0;
        logic [31:0] v1;
        {s, v0, v1} = st;
        if (!de) begin
            v0 = v0 + (xtea_mix(v1) ^ (s + key_word(k, s[1:0])));
            s  = s + DELTA;
            v1 = v1 + (xtea_mix(v0) ^ (s + key_word(k, s[12:11])));
        end else begin
            v1 = v1 - (xtea_mix(v0) ^ (s + key_word(k, s[12:11])));
            s  = s - DELTA;
            v0 = v0 - (xtea_mix(v1) ^ (s + key_word(k, s[1:0])));
        end
        return {s, v0, v1};
    endfunction
`endif

    // Ready only while running free of reset, in IDLE or while the sink drains DONE.
    assign in_ready = rst_n & ((state == S_IDLE) | ((state == S_DONE) & out_ready));
    assign accept   = in_valid & in_ready;
    assign busy     = (state == S_RUN);

    // Chain UNROLL cipher cycles within one clock.
    always_comb begin
        next_st = {sum_r, v0_r, v1_r};
        for (int unsigned i = 0; i < UNROLL; i++) begin
`ifdef TEA_XTEA_EN
            if (xt_r)
                next_st = xtea_step(next_st, key_r, dec_r);
            else
`endif
                next_st = tea_step(next_st, key_r, dec_r);
        end
    end

    // Handshake FSM, clock counter and latched operands; result outputs are registered here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            v0_r      <= '0;
            v1_r      <= '0;
            sum_r     <= '0;
            key_r     <= '0;
            dec_r     <= 1'b0;
`ifdef TEA_XTEA_EN
            xt_r      <= 1'b0;
`endif
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (accept) begin
            // Accept covers both IDLE and the back-to-back DONE hand-off.
            state     <= S_RUN;
            cnt       <= CNT_LOAD;
            v0_r      <= in_data[63:32];
            v1_r      <= in_data[31:0];
            key_r     <= in_key;
            dec_r     <= in_decrypt;
            sum_r     <= in_decrypt ? SUM_DEC : '0;
`ifdef TEA_XTEA_EN
            xt_r      <= in_xtea;
`endif
            out_valid <= 1'b0;
        end else begin
            case (state)
                S_RUN: begin
                    {sum_r, v0_r, v1_r} <= next_st;
                    cnt                 <= cnt - 7'd1;
                    if (cnt == 7'd1) begin
                        state     <= S_DONE;
                        out_valid <= 1'b1;
                        out_data  <= next_st[63:0];
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state     <= S_IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_tea_engine.sv
// tb_tea_engine: three engines (UNROLL 1, 2, 4) driven side by side and checked
// against a plain-arithmetic TEA/XTEA reference and a handshake timing model.
module tb_tea_engine;

    localparam int          ND     = 3;
    localparam int          ROUNDS = 32;
    localparam logic [31:0] DELTA  = 32'h9E3779B9;
    localparam logic [63:0] CT0    = 64'h41EA3A0A94BAA940;
    localparam logic [63:0] XCT0   = 64'hDEE9D4D8F7131ED9;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic [ND-1:0]     in_valid;
    logic [ND-1:0]     in_ready;
    logic [ND-1:0]     in_decrypt;
    logic [ND-1:0]     in_xtea;
    logic [63:0]       in_data [ND];
    logic [127:0]      in_key [ND];
    logic [ND-1:0]     out_valid;
    logic [ND-1:0]     out_ready;
    logic [63:0]       out_data [ND];
    logic [ND-1:0]     busy;

    int                checks = 0;
    int                errors = 0;
    bit                mon_en = 1'b0;
    bit                rand_rdy = 1'b0;
    int                rem [ND];
    bit                hold [ND];
    logic [63:0]       expv [ND];
    logic [63:0]       last [ND];

    always #5 clk = ~clk;

    for (genvar g = 0; g < ND; g++) begin : g_dut
        tea_engine #(
            .ROUNDS(ROUNDS),
            .UNROLL(1 << g),
            .DELTA (DELTA)
        ) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready[g]),
            .in_decrypt(in_decrypt[g]),
            .in_data   (in_data[g]),
            .in_key    (in_key[g]),
`ifdef TEA_XTEA_EN
            .in_xtea   (in_xtea[g]),
`endif
            .out_valid (out_valid[g]),
            .out_ready (out_ready[g]),
            .out_data  (out_data[g]),
            .busy      (busy[g])
        );
    end

    task automatic chkb(input string name, input logic act, input logic want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, want, $time);
        end
    endtask

    task automatic chkw(input string name, input logic [63:0] act, input logic [63:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, want, $time);
        end
    endtask

    // Reference cipher straight from the algorithm description.
    function automatic logic [63:0] ref_block(input logic [63:0] blk, input logic [127:0] key,
                                              input logic dec, input logic xt);
        logic [31:0] v0;
        logic [31:0] v1;
        logic [31:0] sum;
        logic [31:0] k [4];
        v0   = blk[63:32];
        v1   = blk[31:0];
        k[0] = key[127:96];
        k[1] = key[95:64];
        k[2] = key[63:32];
        k[3] = key[31:0];
        sum  = dec ? DELTA * 32'(ROUNDS) : 32'h0;
        for (int i = 0; i < ROUNDS; i++) begin
            if (!xt && !dec) begin
                sum = sum + DELTA;
                v0  = v0 + (((v1 << 4) + k[0]) ^ (v1 + sum) ^ ((v1 >> 5) + k[1]));
                v1  = v1 + (((v0 << 4) + k[2]) ^ (v0 + sum) ^ ((v0 >> 5) + k[3]));
            end else if (!xt) begin
                v1  = v1 - (((v0 << 4) + k[2]) ^ (v0 + sum) ^ ((v0 >> 5) + k[3]));
                v0  = v0 - (((v1 << 4) + k[0]) ^ (v1 + sum) ^ ((v1 >> 5) + k[1]));
                sum = sum - DELTA;
            end else if (!dec) begin
                v0  = v0 + ((((v1 << 4) ^ (v1 >> 5)) + v1) ^ (sum + k[sum[1:0]]));
                sum = sum + DELTA;
                v1  = v1 + ((((v0 << 4) ^ (v0 >> 5)) + v0) ^ (sum + k[sum[12:11]]));
            end else begin
                v1  = v1 - ((((v0 << 4) ^ (v0 >> 5)) + v0) ^ (sum + k[sum[12:11]]));
                sum = sum - DELTA;
                v0  = v0 - ((((v1 << 4) ^ (v1 >> 5)) + v1) ^ (sum + k[sum[1:0]]));
            end
        end
        return {v0, v1};
    endfunction

    function automatic int lat_of(input int d);
        return ROUNDS >> d;
    endfunction

    // Compare process: expected handshake phase and result for every engine, every cycle.
    always @(negedge clk) begin
        if (!rst_n) begin
            for (int d = 0; d < ND; d++) begin
                rem[d]  = -1;
                hold[d] = 1'b0;
                last[d] = '0;
            end
        end else if (mon_en) begin
            for (int d = 0; d < ND; d++) begin
                bit rdy_exp;
                rdy_exp = 1'b0;
                if (hold[d]) begin
                    chkb($sformatf("u%0d hold_valid", d), out_valid[d], 1'b1);
                    chkw($sformatf("u%0d hold_data", d), out_data[d], expv[d]);
                    chkb($sformatf("u%0d hold_busy", d), busy[d], 1'b0);
                    chkb($sformatf("u%0d hold_in_ready", d), in_ready[d], out_ready[d]);
                    if (out_ready[d]) begin
                        hold[d] = 1'b0;
                        last[d] = expv[d];
                        rdy_exp = 1'b1;
                    end
                end else if (rem[d] > 0) begin
                    chkb($sformatf("u%0d run_valid", d), out_valid[d], 1'b0);
                    chkb($sformatf("u%0d run_busy", d), busy[d], 1'b1);
                    chkb($sformatf("u%0d run_in_ready", d), in_ready[d], 1'b0);
                    chkw($sformatf("u%0d run_data", d), out_data[d], last[d]);
                    rem[d]--;
                    if (rem[d] == 0) begin
                        rem[d]  = -1;
                        hold[d] = 1'b1;
                    end
                end else begin
                    chkb($sformatf("u%0d idle_valid", d), out_valid[d], 1'b0);
                    chkb($sformatf("u%0d idle_busy", d), busy[d], 1'b0);
                    chkb($sformatf("u%0d idle_in_ready", d), in_ready[d], 1'b1);
                    chkw($sformatf("u%0d idle_data", d), out_data[d], last[d]);
                    rdy_exp = 1'b1;
                end
                if (rdy_exp && in_valid[d]) begin
                    rem[d]  = lat_of(d);
                    expv[d] = ref_block(in_data[d], in_key[d], in_decrypt[d], in_xtea[d]);
                end
            end
        end
    end

    // Random sink back-pressure during the randomized phase.
    always @(posedge clk) begin
        if (rand_rdy) begin
            #1;
            for (int d = 0; d < ND; d++) out_ready[d] = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic scramble(input int d);
        in_data[d]    = {$urandom(), $urandom()};
        in_key[d]     = {$urandom(), $urandom(), $urandom(), $urandom()};
        in_decrypt[d] = 1'($urandom_range(0, 1));
`ifdef TEA_XTEA_EN
        in_xtea[d]    = 1'($urandom_range(0, 1));
`endif
    endtask

    // Present the same block to every engine at once and measure latency and result.
    task automatic run_vec(input logic dec, input logic [63:0] data, input logic xt,
                           input logic [63:0] want, input bit b2b);
        int lat [ND];
        for (int d = 0; d < ND; d++) begin
            in_valid[d]   = 1'b1;
            in_data[d]    = data;
            in_key[d]     = '0;
            in_decrypt[d] = dec;
            in_xtea[d]    = xt;
            out_ready[d]  = b2b;
        end
        @(negedge clk);
        if (b2b)
            for (int d = 0; d < ND; d++) chkb($sformatf("u%0d b2b_in_ready", d), in_ready[d], 1'b1);
        @(posedge clk);
        #1;
        for (int d = 0; d < ND; d++) begin
            in_valid[d]  = 1'b0;
            out_ready[d] = 1'b0;
            scramble(d);
            lat[d] = 0;
            if (b2b) chkb($sformatf("u%0d b2b_busy", d), busy[d], 1'b1);
        end
        for (int c = 1; c <= ROUNDS + 8; c++) begin
            @(posedge clk);
            #1;
            for (int d = 0; d < ND; d++)
                if (out_valid[d] && lat[d] == 0) lat[d] = c;
        end
        for (int d = 0; d < ND; d++) begin
            chkw($sformatf("u%0d latency", d), 64'(lat[d]), 64'(lat_of(d)));
            chkw($sformatf("u%0d vector", d), out_data[d], want);
        end
    endtask

    task automatic release_all();
        for (int d = 0; d < ND; d++) out_ready[d] = 1'b1;
        @(posedge clk);
        #1;
        for (int d = 0; d < ND; d++) out_ready[d] = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        for (int d = 0; d < ND; d++) begin
            chkb($sformatf("u%0d %s_valid", d, tag), out_valid[d], 1'b0);
            chkb($sformatf("u%0d %s_busy", d, tag), busy[d], 1'b0);
            chkb($sformatf("u%0d %s_in_ready", d, tag), in_ready[d], 1'b0);
            chkw($sformatf("u%0d %s_data", d, tag), out_data[d], 64'h0);
        end
    endtask

    task automatic send(input int d, input logic [63:0] data, input logic [127:0] key,
                        input logic dec, input logic xt);
        int unsigned gap;
        int          waited;
        gap = $urandom_range(0, 2);
        repeat (gap) begin
            in_valid[d] = 1'b0;
            scramble(d);
            @(posedge clk);
            #1;
        end
        in_valid[d]   = 1'b1;
        in_data[d]    = data;
        in_key[d]     = key;
        in_decrypt[d] = dec;
        in_xtea[d]    = xt;
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!in_ready[d] && waited < 200);
        if (!in_ready[d]) chkb($sformatf("u%0d accept_timeout", d), in_ready[d], 1'b1);
        @(posedge clk);
        #1;
        in_valid[d] = 1'b0;
        scramble(d);
    endtask

    // Encrypt a random block, then decrypt the ciphertext under the same key.
    task automatic drive(input int d, input int nb);
        logic [63:0]  pt;
        logic [63:0]  ct;
        logic [127:0] key;
        logic         xt;
        for (int i = 0; i < nb; i++) begin
            pt  = {$urandom(), $urandom()};
            key = {$urandom(), $urandom(), $urandom(), $urandom()};
            xt  = 1'b0;
`ifdef TEA_XTEA_EN
            xt  = 1'($urandom_range(0, 1));
`endif
            ct  = ref_block(pt, key, 1'b0, xt);
            send(d, pt, key, 1'b0, xt);
            send(d, ct, key, 1'b1, xt);
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "time limit");
    end

    initial begin
        for (int d = 0; d < ND; d++) begin
            in_valid[d]   = 1'b0;
            in_decrypt[d] = 1'b0;
            in_xtea[d]    = 1'b0;
            in_data[d]    = '0;
            in_key[d]     = '0;
            out_ready[d]  = 1'b0;
            rem[d]        = -1;
            hold[d]       = 1'b0;
            last[d]       = '0;
            expv[d]       = '0;
        end
        #3 rst_n = 1'b0;
        #1 check_reset_outputs("reset");
        repeat (2) @(posedge clk);
        #1;
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // Zero key/plaintext encrypt, then hold the result under sink stall.
        run_vec(1'b0, 64'h0, 1'b0, CT0, 1'b0);
        repeat (10) begin
            @(posedge clk);
            #1;
            for (int d = 0; d < ND; d++) begin
                chkb($sformatf("u%0d stall_in_ready", d), in_ready[d], 1'b0);
                chkb($sformatf("u%0d stall_valid", d), out_valid[d], 1'b1);
                chkw($sformatf("u%0d stall_data", d), out_data[d], CT0);
            end
        end
        // Back-to-back decrypt accepted on the same edge that drains the result.
        run_vec(1'b1, CT0, 1'b0, 64'h0, 1'b1);
        release_all();

        // Reset asserted twelve clocks into a block.
        for (int d = 0; d < ND; d++) begin
            in_valid[d]   = 1'b1;
            in_data[d]    = 64'h0123456789ABCDEF;
            in_key[d]     = 128'h00112233445566778899AABBCCDDEEFF;
            in_decrypt[d] = 1'b0;
            in_xtea[d]    = 1'b0;
        end
        @(negedge clk);
        @(posedge clk);
        #1;
        for (int d = 0; d < ND; d++) begin
            in_valid[d] = 1'b0;
            scramble(d);
        end
        repeat (12) @(posedge clk);
        #1 rst_n = 1'b0;
        #1 check_reset_outputs("abort");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        run_vec(1'b0, 64'h0, 1'b0, CT0, 1'b0);
        release_all();

`ifdef TEA_XTEA_EN
        run_vec(1'b0, 64'h0, 1'b1, XCT0, 1'b0);
        run_vec(1'b1, XCT0, 1'b1, 64'h0, 1'b1);
        release_all();
`endif

        // Randomized round trips with random gaps, stalls and input churn during RUN.
        rand_rdy = 1'b1;
        fork
            drive(0, 500);
            drive(1, 500);
            drive(2, 500);
        join
        rand_rdy = 1'b0;
        @(posedge clk);
        #2;
        for (int d = 0; d < ND; d++) out_ready[d] = 1'b1;
        repeat (ROUNDS + 4) @(posedge clk);
        #1;
        for (int d = 0; d < ND; d++) begin
            chkb($sformatf("u%0d final_busy", d), busy[d], 1'b0);
            chkb($sformatf("u%0d final_valid", d), out_valid[d], 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
